// File: rtl/seg_scan_reader.sv
// Reads back a multiplexed active-low 7-segment bus and reassembles the digit codes into frames.
// Optional `SEG_ERR_CNT_EN adds a saturating err_count output for unrecognised captures.
module seg_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int IDLE_TIMEOUT  = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    frame_valid,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    disp_off
`ifdef SEG_ERR_CNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [7:0]    STAB_MAX = 8'(STABLE_CYCLES);
  localparam logic [TW-1:0] IDLE_MAX = TW'(IDLE_TIMEOUT);

  typedef enum logic {S_OFF, S_COLLECT} state_t;

  state_t                  state_q;
  logic [NUM_DIGITS-1:0]   an_s1_q, an_s2_q;
  logic [6:0]              seg_s1_q, seg_s2_q;
  logic [IW+6:0]           key_q;
  logic [7:0]              cnt_q, cnt_d;
  logic [TW-1:0]           idle_q, idle_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] slot_val_q;
  logic [NUM_DIGITS-1:0]   slot_blank_q, slot_err_q;

  logic [3:0]    nzero;
  logic [IW-1:0] key_idx;
  logic          key_valid;
  logic [IW+6:0] key;
  logic [3:0]    nib;
  logic          is_blank, is_err;
  logic          capture, publish, timeout;

  always_comb begin
    nzero   = '0;
    key_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s2_q[i]) begin
        nzero   = nzero + 4'd1;
        key_idx = IW'(i);
      end
    end
    key_valid = (nzero == 4'd1);
    key       = {key_idx, seg_s2_q};
  end

  always_comb begin
    is_blank = 1'b0;
    is_err   = 1'b0;
    nib      = 4'hF;
    case (seg_s2_q)
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b1111000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0010000: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b0000011: nib = 4'hB;
      7'b1000110: nib = 4'hC;
      7'b1111111: is_blank = 1'b1;
      default:    is_err = 1'b1;
    endcase
  end

  // Capture fires only on the transition into saturation, so once per stable window.
  always_comb begin
    if (!key_valid)            cnt_d = '0;
    else if (key != key_q)     cnt_d = 8'd1;
    else if (cnt_q < STAB_MAX) cnt_d = cnt_q + 8'd1;
    else                       cnt_d = cnt_q;
    capture = key_valid && (cnt_d == STAB_MAX) && (cnt_q != STAB_MAX);

    if (key_valid)             idle_d = '0;
    else if (idle_q < IDLE_MAX) idle_d = idle_q + 1'b1;
    else                       idle_d = idle_q;
    timeout = (idle_d == IDLE_MAX);

    publish = (state_q == S_COLLECT) && (&seen_q);

    // Publish clears first so a coincident capture counts toward the next frame.
    seen_d = seen_q;
    if (publish) seen_d = '0;
    if (capture) seen_d[key_idx] = 1'b1;
    if (timeout) seen_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_OFF;
      an_s1_q      <= '1;
      an_s2_q      <= '1;
      seg_s1_q     <= '0;
      seg_s2_q     <= '0;
      key_q        <= '0;
      cnt_q        <= '0;
      idle_q       <= '0;
      seen_q       <= '0;
      slot_val_q   <= '0;
      slot_blank_q <= '0;
      slot_err_q   <= '0;
      value        <= '0;
      frame_valid  <= 1'b0;
      blank_mask   <= '0;
      digit_err    <= '0;
      disp_off     <= 1'b1;
    end else begin
      an_s1_q     <= an;
      an_s2_q     <= an_s1_q;
      seg_s1_q    <= seg;
      seg_s2_q    <= seg_s1_q;
      key_q       <= key;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      seen_q      <= seen_d;
      frame_valid <= publish;
      if (publish) begin
        value      <= slot_val_q;
        blank_mask <= slot_blank_q;
        digit_err  <= slot_err_q;
      end
      if (capture) begin
        slot_val_q[{key_idx, 2'b00} +: 4] <= nib;
        slot_blank_q[key_idx]             <= is_blank;
        slot_err_q[key_idx]               <= is_err;
      end
      if (timeout) begin
        state_q  <= S_OFF;
        disp_off <= 1'b1;
      end else if (capture && state_q == S_OFF) begin
        state_q  <= S_COLLECT;
        disp_off <= 1'b0;
      end
    end
  end

`ifdef SEG_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  err_count <= '0;
    else if (capture && is_err && err_count != '1) err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_seg_scan_reader.sv
// Scoreboard bench for seg_scan_reader: expected frames are queued by stimulus and
// checked by a monitor whenever frame_valid pulses.
module tb_seg_scan_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] value;
  logic        frame_valid;
  logic [3:0]  blank_mask, digit_err;
  logic        disp_off;
`ifdef SEG_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_q[$];

  localparam logic [6:0] P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000,
                         P4 = 7'b0011001, P7 = 7'b1111000, P9 = 7'b0010000,
                         PBL = 7'b1111111, PBAD = 7'b0101010;

  seg_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4), .IDLE_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .value(value),
    .frame_valid(frame_valid), .blank_mask(blank_mask), .digit_err(digit_err),
    .disp_off(disp_off)
`ifdef SEG_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got value %0h expected no frame", value);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("frame_value", {16'h0, value}, {16'h0, e[23:8]});
        chk("frame_blank", {28'h0, blank_mask}, {28'h0, e[7:4]});
        chk("frame_err", {28'h0, digit_err}, {28'h0, e[3:0]});
      end
    end
  end

  task automatic show(input int idx, input logic [6:0] pat, input int n);
    an  = ~(4'b0001 << idx);
    seg = pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] d3, input logic [6:0] d2,
                      input logic [6:0] d1, input logic [6:0] d0);
    show(3, d3, 8);
    show(2, d2, 8);
    show(1, d1, 8);
    show(0, d0, 8);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_value"}, {16'h0, value}, 32'h0);
    chk({tag, "_fv"}, {31'h0, frame_valid}, 32'h0);
    chk({tag, "_blank"}, {28'h0, blank_mask}, 32'h0);
    chk({tag, "_err"}, {28'h0, digit_err}, 32'h0);
    chk({tag, "_off"}, {31'h0, disp_off}, 32'h1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // First scan; disp_off must still be high before the first capture edge.
    exp_q.push_back({16'h1234, 4'b0000, 4'b0000});
    show(3, P1, 5);
    chk("off_before_capture", {31'h0, disp_off}, 32'h1);
    show(3, P1, 3);
    chk("off_after_capture", {31'h0, disp_off}, 32'h0);
    show(2, P2, 8);
    show(1, P3, 8);
    show(0, P4, 8);

    // Blank and unrecognised digits.
    exp_q.push_back({16'h1F3F, 4'b0100, 4'b0001});
    scan(P1, PBL, P3, PBAD);

    // Glitching segments and two anodes low: neither may capture.
    for (int k = 0; k < 10; k++) show(1, (k % 2 == 0) ? P3 : P2, 2);
    an = 4'b1001;
    repeat (20) @(negedge clk);

    // Digit 0 shown twice before the frame completes; latest wins.
    exp_q.push_back({16'h1239, 4'b0000, 4'b0000});
    show(0, P7, 8);
    show(3, P1, 8);
    show(0, P9, 8);
    show(2, P2, 8);
    show(1, P3, 8);

    // Idle timeout keeps the last frame.
    exp_q.push_back({16'h1234, 4'b0000, 4'b0000});
    scan(P1, P2, P3, P4);
    an = 4'hF;
    repeat (60) @(negedge clk);
    chk("idle_before_timeout", {31'h0, disp_off}, 32'h0);
    repeat (10) @(negedge clk);
    chk("idle_after_timeout", {31'h0, disp_off}, 32'h1);
    chk("idle_value_held", {16'h0, value}, 32'h1234);
    exp_q.push_back({16'h1234, 4'b0000, 4'b0000});
    scan(P1, P2, P3, P4);
    chk("off_cleared_rescan", {31'h0, disp_off}, 32'h0);

    // Reset after two of four digits.
    show(3, P4, 8);
    show(2, P3, 8);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("postrst");
    exp_q.push_back({16'h4321, 4'b0000, 4'b0000});
    scan(P4, P3, P2, P1);

`ifdef SEG_ERR_CNT_EN
    for (int k = 0; k < 300; k++) show(0, (k % 2 == 0) ? PBAD : 7'b0101011, 6);
    chk("err_count_sat", {24'h0, err_count}, 32'd255);
`endif

    an = 4'hF;
    repeat (10) @(negedge clk);
    chk("frames_outstanding", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
